// File: rtl/cloud_pkg.sv
// Shared widths, LFSR taps and the park/spawn position helper for the cloud scroller.
package cloud_pkg;
  localparam int H_W    = 10;
  localparam int V_W    = 10;
  localparam int VEL_W  = 6;
  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic int cloud_park_h(input int screen_w, input int cloud_w);
    return screen_w + cloud_w;
  endfunction
endpackage

// File: rtl/cloud_lfsr.sv
// 16-bit Fibonacci LFSR that advances only when en is high; reset loads seed.
module cloud_lfsr
  import cloud_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= seed;
    end else if (en) begin
      state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/cloud_field.sv
// Multi-slot background cloud scroller: moves, retires and respawns clouds on each frame tick.
// Define CLOUD_PARALLAX_EN to make odd-numbered slots scroll at half the base speed.
module cloud_field
  import cloud_pkg::*;
#(
  parameter int          NUM_CLOUDS   = 3,
  parameter int          SCREEN_W     = 640,
  parameter int          CLOUD_W      = 80,
  parameter int          CLOUD_H      = 30,
  parameter int          FIRST_V      = 170,
  parameter int          V_MIN        = 40,
  parameter int          V_RANGE_LOG2 = 7,
  parameter int          SPAWN_TICKS  = 60,
  parameter int          DEF_HVEL     = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      run,
  input  logic                      speed_load,
  input  logic [VEL_W-1:0]          speed_in,
  output logic [H_W*NUM_CLOUDS-1:0] cloud_h,
  output logic [V_W*NUM_CLOUDS-1:0] cloud_v,
  output logic [NUM_CLOUDS-1:0]     cloud_active,
  output logic [VEL_W-1:0]          cloud_hvel
);

  localparam int              TIMER_W = 16;
  localparam logic [H_W-1:0]  PARK_H  = H_W'(cloud_park_h(SCREEN_W, CLOUD_W));

  if (SCREEN_W + CLOUD_W >= 1024) begin : g_bad_park
    $error("cloud_field: SCREEN_W+CLOUD_W must be below 1024");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("cloud_field: LFSR_SEED must be non-zero");
  end

  function automatic logic [VEL_W-1:0] clamp_vel(input logic [VEL_W-1:0] v);
    return (v == '0) ? VEL_W'(1) : v;
  endfunction

  logic                 eff_tick;
  logic [LFSR_W-1:0]    lfsr_q;
  logic                 unused_lfsr;
  logic [VEL_W-1:0]     hvel_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [NUM_CLOUDS-1:0] active_w;
  logic [NUM_CLOUDS-1:0] free_sel;
  logic                 any_free;
  logic                 spawn_now;
  logic [V_W-1:0]       spawn_v;

  assign eff_tick    = tick & run;
  assign any_free    = ~&active_w;
  assign spawn_now   = eff_tick & (timer_q == '0) & any_free;
  assign spawn_v     = V_W'(V_MIN) + V_W'(lfsr_q[V_RANGE_LOG2-1:0]);
  assign unused_lfsr = ^lfsr_q;

  cloud_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (eff_tick),
    .seed  (LFSR_SEED),
    .state (lfsr_q)
  );

  // Lowest-index slot that was inactive at the start of this tick
  always_comb begin
    logic found;
    free_sel = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_CLOUDS; k++) begin
      if (!active_w[k] && !found) begin
        free_sel[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hvel_q  <= VEL_W'(DEF_HVEL);
      timer_q <= TIMER_W'(SPAWN_TICKS);
    end else begin
      if (speed_load) begin
        hvel_q <= clamp_vel(speed_in);
      end
      if (eff_tick) begin
        if (timer_q != '0) begin
          timer_q <= timer_q - TIMER_W'(1);
        end else if (any_free) begin
          timer_q <= TIMER_W'(SPAWN_TICKS) + TIMER_W'(lfsr_q[3:0]);
        end
      end
    end
  end

  assign cloud_hvel   = hvel_q;
  assign cloud_active = active_w;

  for (genvar i = 0; i < NUM_CLOUDS; i++) begin : g_slot
    localparam logic [V_W-1:0] RST_V   = (i == 0) ? V_W'(FIRST_V) : V_W'(V_MIN);
    localparam logic           RST_ACT = (i == 0);

    logic [VEL_W-1:0] vel;
    logic [H_W-1:0]   vel_ext;
    logic [H_W-1:0]   h_q;
    logic [V_W-1:0]   v_q;
    logic             act_q;

`ifdef CLOUD_PARALLAX_EN
    assign vel = clamp_vel(hvel_q >> (i % 2));
`else
    assign vel = hvel_q;
`endif
    assign vel_ext = {{(H_W-VEL_W){1'b0}}, vel};

    // A slot that retires on this tick stays out of free_sel until the next one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        h_q   <= PARK_H;
        v_q   <= RST_V;
        act_q <= RST_ACT;
      end else if (eff_tick) begin
        if (act_q) begin
          if (h_q > vel_ext) begin
            h_q <= h_q - vel_ext;
          end else begin
            act_q <= 1'b0;
            h_q   <= PARK_H;
          end
        end else if (spawn_now && free_sel[i]) begin
          act_q <= 1'b1;
          h_q   <= PARK_H;
          v_q   <= spawn_v;
        end
      end
    end

    assign cloud_h[H_W*i +: H_W] = h_q;
    assign cloud_v[V_W*i +: V_W] = v_q;
    assign active_w[i]           = act_q;
  end

endmodule

// File: tb/tb_cloud_field.sv
// Self-checking bench for cloud_field: vector table, directed corner sequences and a
// randomized run against a behavioural model. Honours CLOUD_PARALLAX_EN like the design.
module tb_cloud_field;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        run = 1'b0;
  logic        speed_load = 1'b0;
  logic [5:0]  speed_in = 6'd0;
  logic [29:0] cloud_h;
  logic [29:0] cloud_v;
  logic [2:0]  cloud_active;
  logic [5:0]  cloud_hvel;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int mh[3];
  int mv[3];
  bit ma[3];
  int mhvel;
  int mtimer;
  int mlfsr;

  typedef struct {
    logic       tk;
    logic       rn;
    logic       ld;
    logic [5:0] spd;
    int         exp_h0;
    logic       exp_a0;
    int         exp_hvel;
  } vec_t;

  vec_t tbl[10];

  cloud_field dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .run          (run),
    .speed_load   (speed_load),
    .speed_in     (speed_in),
    .cloud_h      (cloud_h),
    .cloud_v      (cloud_v),
    .cloud_active (cloud_active),
    .cloud_hvel   (cloud_hvel)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic int slot_vel(input int i);
`ifdef CLOUD_PARALLAX_EN
    int v;
    v = (i % 2 == 1) ? mhvel / 2 : mhvel;
    return (v < 1) ? 1 : v;
`else
    return mhvel;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 720;
      mv[i] = (i == 0) ? 170 : 40;
      ma[i] = (i == 0);
    end
    mhvel  = 5;
    mtimer = 60;
    mlfsr  = 16'hACE1;
  endtask

  task automatic model_step(input logic t, input logic r, input logic l, input int s);
    int free_idx;
    int v;
    if (t && r) begin
      free_idx = -1;
      for (int i = 0; i < 3; i++)
        if (!ma[i] && free_idx < 0) free_idx = i;
      for (int i = 0; i < 3; i++) begin
        if (ma[i]) begin
          v = slot_vel(i);
          if (mh[i] > v) mh[i] = mh[i] - v;
          else begin
            ma[i] = 0;
            mh[i] = 720;
          end
        end
      end
      if (mtimer > 0) mtimer = mtimer - 1;
      else if (free_idx >= 0) begin
        ma[free_idx] = 1;
        mh[free_idx] = 720;
        mv[free_idx] = 40 + (mlfsr % 128);
        mtimer       = 60 + (mlfsr % 16);
      end
      mlfsr = lfsr_next(mlfsr);
    end
    if (l) mhvel = (s == 0) ? 1 : s;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    logic [29:0] eh;
    logic [29:0] ev;
    logic [2:0]  ea;
    for (int i = 0; i < 3; i++) begin
      eh[10*i +: 10] = 10'(mh[i]);
      ev[10*i +: 10] = 10'(mv[i]);
      ea[i]          = ma[i];
    end
    chk({name, ".h"}, 32'(cloud_h), 32'(eh));
    chk({name, ".v"}, 32'(cloud_v), 32'(ev));
    chk({name, ".active"}, 32'(cloud_active), 32'(ea));
    chk({name, ".hvel"}, 32'(cloud_hvel), 32'(mhvel));
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic t, input logic r, input logic l, input logic [5:0] s);
    @(negedge clk);
    tick       = t;
    run        = r;
    speed_load = l;
    speed_in   = s;
    @(posedge clk);
    #1;
    model_step(t, r, l, int'(s));
    tick       = 1'b0;
    speed_load = 1'b0;
  endtask

  task automatic run_ticks(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b1, 1'b0, 6'd0);
      check_all(name);
    end
  endtask

  // Reset pulse placed between clock edges; outputs are checked before the next edge
  task automatic do_reset(input string name);
    @(negedge clk);
    tick       = 1'b0;
    speed_load = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all(name);
    #1 rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 6'd0,  715, 1'b1, 5};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 6'd0,  715, 1'b1, 5};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 6'd0,  715, 1'b1, 5};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 6'd0,  715, 1'b1, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 6'd0,  714, 1'b1, 1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 6'd12, 713, 1'b1, 12};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 6'd0,  701, 1'b1, 12};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 6'd63, 701, 1'b1, 63};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 6'd0,  638, 1'b1, 63};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 6'd5,  575, 1'b1, 5};

    // Reset values
    do_reset("reset");
    chk("rst_h0", 32'(cloud_h[9:0]), 32'd720);
    chk("rst_v0", 32'(cloud_v[9:0]), 32'd170);
    chk("rst_active", 32'(cloud_active), 32'b001);
    chk("rst_hvel", 32'(cloud_hvel), 32'd5);

    // Vector table: run gating, speed clamp, speed load colliding with a tick
    for (int n = 0; n < 10; n++) begin
      step(tbl[n].tk, tbl[n].rn, tbl[n].ld, tbl[n].spd);
      chk($sformatf("tbl%0d.h0", n), 32'(cloud_h[9:0]), 32'(tbl[n].exp_h0));
      chk($sformatf("tbl%0d.a0", n), 32'(cloud_active[0]), 32'(tbl[n].exp_a0));
      chk($sformatf("tbl%0d.hvel", n), 32'(cloud_hvel), 32'(tbl[n].exp_hvel));
    end

    // Motion then freeze
    do_reset("reset2");
    run_ticks(10, "motion");
    chk("motion_h0", 32'(cloud_h[9:0]), 32'd670);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 6'd0);
      check_all("freeze");
    end
    chk("freeze_h0", 32'(cloud_h[9:0]), 32'd670);
    chk("freeze_lfsr", 32'(dut.u_lfsr.state), 32'(mlfsr));

    // Exit boundary h == vel
    do_reset("reset3");
    run_ticks(143, "to_exit");
    chk("pre_exit_h0", 32'(cloud_h[9:0]), 32'd5);
    chk("pre_exit_a0", 32'(cloud_active[0]), 32'd1);
    run_ticks(1, "exit");
    chk("exit_a0", 32'(cloud_active[0]), 32'd0);
    chk("exit_h0", 32'(cloud_h[9:0]), 32'd720);

    // h just above vel keeps moving
    do_reset("reset4");
    step(1'b0, 1'b1, 1'b1, 6'd6);
    run_ticks(119, "to_six");
    chk("six_h0", 32'(cloud_h[9:0]), 32'd6);
    step(1'b0, 1'b1, 1'b1, 6'd5);
    run_ticks(1, "six_minus5");
    chk("one_h0", 32'(cloud_h[9:0]), 32'd1);
    chk("one_a0", 32'(cloud_active[0]), 32'd1);

    // First spawn timing
    do_reset("reset5");
    run_ticks(60, "pre_spawn");
    chk("pre_spawn_a1", 32'(cloud_active[1]), 32'd0);
    run_ticks(1, "spawn");
    chk("spawn_a1", 32'(cloud_active[1]), 32'd1);
    chk("spawn_h1", 32'(cloud_h[19:10]), 32'd720);
    chk("spawn_v1_range", 32'(cloud_v[19:10] >= 10'd40 && cloud_v[19:10] <= 10'd167), 32'd1);

    // Full field holds the timer; freed slot respawns one tick after its exit
    do_reset("reset6");
    step(1'b0, 1'b1, 1'b1, 6'd1);
    run_ticks(719, "full_field");
    chk("full_active", 32'(cloud_active), 32'b111);
    run_ticks(1, "full_exit");
    chk("full_exit_a0", 32'(cloud_active[0]), 32'd0);
    run_ticks(1, "full_respawn");
    chk("full_respawn_a0", 32'(cloud_active[0]), 32'd1);
    chk("full_respawn_h0", 32'(cloud_h[9:0]), 32'd720);

`ifdef CLOUD_PARALLAX_EN
    do_reset("reset_px");
    step(1'b0, 1'b1, 1'b1, 6'd8);
    run_ticks(62, "parallax");
    chk("parallax_h1", 32'(cloud_h[19:10]), 32'd716);
`endif

    // Randomized scroll with occasional async reset mid-operation
    do_reset("reset_rand");
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rand_reset");
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 39) == 0), 6'($urandom_range(0, 15)));
        check_all("rand");
      end
    end
    chk("rand_lfsr", 32'(dut.u_lfsr.state), 32'(mlfsr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
